ctrl_fifo_buf_adc_seq: RTL and testbench

- Sequenced successor to the fixed always-enabled ADC FIFO buffer controller.
- Gates FIFO write enables from ADC sample-valid strobes over a programmable frame length.
- Issues FIFO read enables to the downstream stream interface by fill threshold and drain phase.
- Reports overflow, sample count, last-read and done status; sits between the ADC capture path and the FIFO feeding the PS stream DMA.

---
 rtl/ctrl_fifo_buf_adc_seq.sv | 174 +++++++++++++++++
 tb/tb_ctrl_fifo_buf_adc_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fifo_buf_adc_seq.sv
// Sequenced ADC-to-FIFO capture controller: frame-gated writes, threshold/drain reads.
// Optional sample decimation is built when CTRL_FIFO_ADC_DECIM_EN is defined.
module ctrl_fifo_buf_adc_seq #(
  parameter int COUNT_W     = 11,
  parameter int LEN_W       = 16,
  parameter int READ_THRESH = 256,
  parameter int DECIM_W     = 8
) (
  input  logic               Clk_i,
  input  logic               Rst_i,
  input  logic               Start_i,
  input  logic               Stop_i,
  input  logic [LEN_W-1:0]   FrameLen_i,
  input  logic [DECIM_W-1:0] Decim_i,
  input  logic               AdcValid_i,
  input  logic               FifoFull_i,
  input  logic               FifoEmpty_i,
  input  logic [COUNT_W-1:0] FifoCount_i,
  input  logic               StreamReady_i,
  output logic               FifoWriteEn_o,
  output logic               FifoReadEn_o,
  output logic               LastRead_o,
  output logic [LEN_W-1:0]   SampleCnt_o,
  output logic               Overflow_o,
  output logic               Busy_o,
  output logic               Done_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] THRESH = COUNT_W'(READ_THRESH);

  state_t             state_r;
  state_t             stateNext_s;
  logic [LEN_W-1:0]   frameLen_r;
  logic [LEN_W-1:0]   sampleCnt_r;
  logic               overflow_r;
  logic               done_r;
  logic               keep_s;
  logic               accept_s;
  logic               writeEn_s;
  logic               readEn_s;
  logic               lastRead_s;
  logic               busy_s;
  logic               startIdle_s;

  assign startIdle_s = (state_r == IDLE) & Start_i;

`ifdef CTRL_FIFO_ADC_DECIM_EN
  logic [DECIM_W-1:0] decimCnt_r;

  // Decimation phase: counts every valid in CAPTURE, wraps after reaching Decim_i
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      decimCnt_r <= '0;
    end else if (startIdle_s) begin
      decimCnt_r <= '0;
    end else if ((state_r == CAPTURE) && AdcValid_i) begin
      if (decimCnt_r == Decim_i) begin
        decimCnt_r <= '0;
      end else begin
        decimCnt_r <= decimCnt_r + DECIM_W'(1);
      end
    end
  end

  assign keep_s = (decimCnt_r == '0);
`else
  logic unusedDecim_s;
  assign unusedDecim_s = ^Decim_i;
  assign keep_s        = 1'b1;
`endif

  assign accept_s = AdcValid_i & keep_s;

  // State register
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state decode and raw strobes
  always_comb begin
    stateNext_s = state_r;
    writeEn_s   = 1'b0;
    readEn_s    = 1'b0;
    lastRead_s  = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start_i) begin
          stateNext_s = CAPTURE;
        end else begin
          stateNext_s = IDLE;
        end
      end
      CAPTURE: begin
        busy_s    = 1'b1;
        writeEn_s = accept_s & ~FifoFull_i;
        readEn_s  = StreamReady_i & ~FifoEmpty_i & (FifoCount_i >= THRESH);
        // The write that completes a bounded frame still lands before draining
        if (Stop_i || (writeEn_s && (frameLen_r != '0) &&
                       (sampleCnt_r == frameLen_r - LEN_W'(1)))) begin
          stateNext_s = DRAIN;
        end else begin
          stateNext_s = CAPTURE;
        end
      end
      DRAIN: begin
        busy_s     = 1'b1;
        readEn_s   = StreamReady_i & ~FifoEmpty_i;
        lastRead_s = readEn_s & (FifoCount_i == COUNT_W'(1));
        if (FifoEmpty_i) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = DRAIN;
        end
      end
      DONE: begin
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Latched frame length, saturating sample count and sticky overflow
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      frameLen_r  <= '0;
      sampleCnt_r <= '0;
      overflow_r  <= 1'b0;
    end else if (startIdle_s) begin
      frameLen_r  <= FrameLen_i;
      sampleCnt_r <= '0;
      overflow_r  <= 1'b0;
    end else if (state_r == CAPTURE) begin
      if (writeEn_s && (sampleCnt_r != {LEN_W{1'b1}})) begin
        sampleCnt_r <= sampleCnt_r + LEN_W'(1);
      end
      if (accept_s && FifoFull_i) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Completion pulse, high exactly while the FSM sits in DONE
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (stateNext_s == DONE);
    end
  end

  // Strobes are forced low while reset is held, whatever the stale state
  assign FifoWriteEn_o = writeEn_s & ~Rst_i;
  assign FifoReadEn_o  = readEn_s & ~Rst_i;
  assign LastRead_o    = lastRead_s & ~Rst_i;
  assign Busy_o        = busy_s & ~Rst_i;
  assign SampleCnt_o   = sampleCnt_r;
  assign Overflow_o    = overflow_r;
  assign Done_o        = done_r;

endmodule

// File: tb/tb_ctrl_fifo_buf_adc_seq.sv
// Self-checking bench for ctrl_fifo_buf_adc_seq: FIFO model plus scoreboard of expected read order.
`timescale 1ns/1ps
module tb_ctrl_fifo_buf_adc_seq;
  localparam int COUNT_W  = 11;
  localparam int LEN_W    = 16;
  localparam int DECIM_W  = 8;
  localparam int THRESH   = 4;
  localparam int FIFO_CAP = 1024;

  logic               clk = 1'b0;
  logic               Rst_i, Start_i, Stop_i, AdcValid_i, StreamReady_i;
  logic [LEN_W-1:0]   FrameLen_i;
  logic [DECIM_W-1:0] Decim_i;
  logic               FifoFull_i, FifoEmpty_i;
  logic [COUNT_W-1:0] FifoCount_i;
  logic               FifoWriteEn_o, FifoReadEn_o, LastRead_o, Overflow_o, Busy_o, Done_o;
  logic [LEN_W-1:0]   SampleCnt_o;

  logic forceFull;
  int   checks = 0;
  int   failures = 0;
  int   fifoQ[$];
  int   expQ[$];
  int   wrCount, rdCount, lastCount, lastId, doneCount, doneDouble;
  int   curId, idS, v, e;
  logic weS, reS, lastS, prevDone;

  ctrl_fifo_buf_adc_seq #(
    .COUNT_W(COUNT_W), .LEN_W(LEN_W), .READ_THRESH(THRESH), .DECIM_W(DECIM_W)
  ) dut (
    .Clk_i(clk), .Rst_i(Rst_i), .Start_i(Start_i), .Stop_i(Stop_i),
    .FrameLen_i(FrameLen_i), .Decim_i(Decim_i), .AdcValid_i(AdcValid_i),
    .FifoFull_i(FifoFull_i), .FifoEmpty_i(FifoEmpty_i), .FifoCount_i(FifoCount_i),
    .StreamReady_i(StreamReady_i), .FifoWriteEn_o(FifoWriteEn_o),
    .FifoReadEn_o(FifoReadEn_o), .LastRead_o(LastRead_o), .SampleCnt_o(SampleCnt_o),
    .Overflow_o(Overflow_o), .Busy_o(Busy_o), .Done_o(Done_o)
  );

  always #5 clk = ~clk;

  assign FifoFull_i  = forceFull | (FifoCount_i >= COUNT_W'(FIFO_CAP - 1));
  assign FifoEmpty_i = (FifoCount_i == '0);

  // Sample DUT strobes mid-cycle
  always @(negedge clk) begin
    weS   = FifoWriteEn_o;
    reS   = FifoReadEn_o;
    lastS = LastRead_o;
    idS   = curId;
    if (Done_o) begin
      doneCount++;
      if (prevDone) doneDouble++;
    end
    prevDone = Done_o;
  end

  // FIFO model and read-order scoreboard, applied just after each active edge
  always begin
    @(posedge clk);
    #1;
    if (lastS) begin
      checks++;
      if (!reS) begin
        failures++;
        $display("FAIL last_without_read: LastRead_o=1 FifoReadEn_o=%0b required 1", reS);
      end
    end
    if (reS) begin
      checks++;
      if (fifoQ.size() == 0 || expQ.size() == 0) begin
        failures++;
        $display("FAIL read_order: read with fifo=%0d exp=%0d entries, required both nonzero",
                 fifoQ.size(), expQ.size());
      end else begin
        v = fifoQ.pop_front();
        e = expQ.pop_front();
        rdCount++;
        if (lastS) begin
          lastCount++;
          lastId = v;
        end
        if (v !== e) begin
          failures++;
          $display("FAIL read_order: got sample %0d required %0d", v, e);
        end
      end
    end
    if (weS) begin
      wrCount++;
      fifoQ.push_back(idS);
    end
    FifoCount_i = COUNT_W'(fifoQ.size());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    wrCount = 0; rdCount = 0; lastCount = 0; lastId = 0; doneCount = 0; doneDouble = 0;
  endtask

  task automatic startFrame(input int len);
    FrameLen_i = LEN_W'(len);
    Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!(doneCount > 0 && !Busy_o) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL %s_timeout: done=%0d busy=%0b required done>0 busy=0", name, doneCount, Busy_o);
    end
  endtask

  task automatic test_reset();
    Rst_i = 1'b1; Start_i = 1'b0; Stop_i = 1'b0; AdcValid_i = 1'b0; StreamReady_i = 1'b1;
    forceFull = 1'b0; FrameLen_i = '0; Decim_i = '0; curId = 0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({FifoWriteEn_o, FifoReadEn_o, LastRead_o, Busy_o, Done_o, Overflow_o} !== 6'b0 ||
        SampleCnt_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: we/re/last/busy/done/ovf=%b cnt=%0d required all 0",
               {FifoWriteEn_o, FifoReadEn_o, LastRead_o, Busy_o, Done_o, Overflow_o}, SampleCnt_o);
    end
    tick();
    Rst_i = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (Busy_o !== 1'b0 || Done_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%0b done=%0b required 0 0", Busy_o, Done_o);
    end
  endtask

  task automatic test_frame8();
    clearStats();
    for (int i = 1; i <= 8; i++) expQ.push_back(i);
    startFrame(8);
    for (int i = 1; i <= 12; i++) begin
      AdcValid_i = 1'b1; curId = i;
      tick();
    end
    AdcValid_i = 1'b0;
    waitDone("frame8");
    @(negedge clk);
    checks++;
    if (wrCount !== 8 || SampleCnt_o !== 16'd8) begin
      failures++;
      $display("FAIL frame8_writes: writes=%0d cnt=%0d required 8 8", wrCount, SampleCnt_o);
    end
    checks++;
    if (rdCount !== 8 || lastCount !== 1 || lastId !== 8) begin
      failures++;
      $display("FAIL frame8_reads: reads=%0d last=%0d lastId=%0d required 8 1 8",
               rdCount, lastCount, lastId);
    end
    checks++;
    if (doneCount !== 1 || doneDouble !== 0 || Busy_o !== 1'b0 || fifoQ.size() != 0) begin
      failures++;
      $display("FAIL frame8_done: done=%0d dbl=%0d busy=%0b fifo=%0d required 1 0 0 0",
               doneCount, doneDouble, Busy_o, fifoQ.size());
    end
  endtask

  task automatic test_stop();
    clearStats();
    for (int i = 1; i <= 20; i++) expQ.push_back(i);
    startFrame(0);
    for (int i = 1; i <= 20; i++) begin
      AdcValid_i = 1'b1; curId = i; Stop_i = (i == 20);
      tick();
    end
    AdcValid_i = 1'b0; Stop_i = 1'b0;
    waitDone("stop");
    @(negedge clk);
    checks++;
    if (wrCount !== 20 || SampleCnt_o !== 16'd20 || rdCount !== 20) begin
      failures++;
      $display("FAIL stop_counts: writes=%0d cnt=%0d reads=%0d required 20 20 20",
               wrCount, SampleCnt_o, rdCount);
    end
    checks++;
    if (doneCount !== 1 || lastId !== 20 || expQ.size() != 0) begin
      failures++;
      $display("FAIL stop_done: done=%0d lastId=%0d pending=%0d required 1 20 0",
               doneCount, lastId, expQ.size());
    end
  endtask

  task automatic test_overflow();
    clearStats();
    for (int i = 1; i <= 13; i++) if (i < 4 || i > 6) expQ.push_back(i);
    startFrame(10);
    for (int i = 1; i <= 16; i++) begin
      AdcValid_i = 1'b1; curId = i; forceFull = (i >= 4 && i <= 6);
      if (i == 7) begin
        @(negedge clk);
        checks++;
        if (Overflow_o !== 1'b1 || SampleCnt_o !== 16'd3) begin
          failures++;
          $display("FAIL overflow_set: ovf=%0b cnt=%0d required 1 3", Overflow_o, SampleCnt_o);
        end
      end
      tick();
    end
    AdcValid_i = 1'b0; forceFull = 1'b0;
    waitDone("overflow");
    @(negedge clk);
    checks++;
    if (wrCount !== 10 || SampleCnt_o !== 16'd10 || rdCount !== 10 || Overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL overflow_frame: writes=%0d cnt=%0d reads=%0d ovf=%0b required 10 10 10 1",
               wrCount, SampleCnt_o, rdCount, Overflow_o);
    end
    clearStats();
    expQ.push_back(100); expQ.push_back(101);
    startFrame(2);
    @(negedge clk);
    checks++;
    if (Overflow_o !== 1'b0 || SampleCnt_o !== 16'd0) begin
      failures++;
      $display("FAIL overflow_clear: ovf=%0b cnt=%0d required 0 0", Overflow_o, SampleCnt_o);
    end
    for (int i = 100; i <= 101; i++) begin
      AdcValid_i = 1'b1; curId = i;
      tick();
    end
    AdcValid_i = 1'b0;
    waitDone("overflow_next");
    @(negedge clk);
    checks++;
    if (rdCount !== 2 || lastId !== 101 || Overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL overflow_next: reads=%0d lastId=%0d ovf=%0b required 2 101 0",
               rdCount, lastId, Overflow_o);
    end
  endtask

  task automatic test_threshold();
    clearStats();
    for (int i = 1; i <= 6; i++) expQ.push_back(i);
    StreamReady_i = 1'b1;
    startFrame(6);
    for (int i = 1; i <= 3; i++) begin
      AdcValid_i = 1'b1; curId = i;
      tick();
    end
    AdcValid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (FifoReadEn_o !== 1'b0 || Busy_o !== 1'b1) begin
      failures++;
      $display("FAIL thresh_below: re=%0b busy=%0b at count 3 required 0 1", FifoReadEn_o, Busy_o);
    end
    AdcValid_i = 1'b1; curId = 4;
    tick();
    AdcValid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (FifoReadEn_o !== 1'b1) begin
      failures++;
      $display("FAIL thresh_reached: re=%0b at count 4 required 1", FifoReadEn_o);
    end
    tick();
    StreamReady_i = 1'b0;
    for (int i = 5; i <= 6; i++) begin
      AdcValid_i = 1'b1; curId = i;
      tick();
    end
    AdcValid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      Start_i = (k == 2);
      @(negedge clk);
      checks++;
      if (FifoReadEn_o !== 1'b0 || Busy_o !== 1'b1 || Done_o !== 1'b0) begin
        failures++;
        $display("FAIL drain_stall: cycle %0d re=%0b busy=%0b done=%0b required 0 1 0",
                 k, FifoReadEn_o, Busy_o, Done_o);
      end
      tick();
    end
    Start_i = 1'b0;
    StreamReady_i = 1'b1;
    waitDone("thresh");
    @(negedge clk);
    checks++;
    if (wrCount !== 6 || rdCount !== 6 || doneCount !== 1 || SampleCnt_o !== 16'd6 || Busy_o !== 1'b0) begin
      failures++;
      $display("FAIL thresh_end: writes=%0d reads=%0d done=%0d cnt=%0d busy=%0b required 6 6 1 6 0",
               wrCount, rdCount, doneCount, SampleCnt_o, Busy_o);
    end
  endtask

  task automatic test_reset_mid();
    clearStats();
    StreamReady_i = 1'b0;
    startFrame(0);
    for (int i = 1; i <= 50; i++) begin
      AdcValid_i = 1'b1; curId = i;
      tick();
    end
    Rst_i = 1'b1;
    StreamReady_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({FifoWriteEn_o, FifoReadEn_o, LastRead_o, Busy_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_during: we/re/last/busy=%b required 0000",
               {FifoWriteEn_o, FifoReadEn_o, LastRead_o, Busy_o});
    end
    tick();
    Rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({FifoWriteEn_o, FifoReadEn_o, Busy_o, Done_o, Overflow_o} !== 5'b0 || SampleCnt_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_after: we/re/busy/done/ovf=%b cnt=%0d required 00000 0",
               {FifoWriteEn_o, FifoReadEn_o, Busy_o, Done_o, Overflow_o}, SampleCnt_o);
    end
    repeat (5) tick();
    AdcValid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wrCount !== 50 || rdCount !== 0 || doneCount !== 0) begin
      failures++;
      $display("FAIL reset_mid_nodrain: writes=%0d reads=%0d done=%0d required 50 0 0",
               wrCount, rdCount, doneCount);
    end
    fifoQ.delete();
    expQ.delete();
    repeat (2) tick();
  endtask

  task automatic test_decim();
    int lastExp;
    clearStats();
    Decim_i = 8'd3;
`ifdef CTRL_FIFO_ADC_DECIM_EN
    expQ.push_back(1); expQ.push_back(5); expQ.push_back(9); expQ.push_back(13);
    lastExp = 13;
`else
    for (int i = 1; i <= 4; i++) expQ.push_back(i);
    lastExp = 4;
`endif
    startFrame(4);
    for (int i = 1; i <= 16; i++) begin
      AdcValid_i = 1'b1; curId = i;
      tick();
    end
    AdcValid_i = 1'b0;
    waitDone("decim");
    @(negedge clk);
    checks++;
    if (wrCount !== 4 || rdCount !== 4 || lastId !== lastExp || SampleCnt_o !== 16'd4 ||
        doneCount !== 1 || Overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL decim: writes=%0d reads=%0d lastId=%0d cnt=%0d done=%0d ovf=%0b required 4 4 %0d 4 1 0",
               wrCount, rdCount, lastId, SampleCnt_o, doneCount, Overflow_o, lastExp);
    end
    Decim_i = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    weS = 1'b0; reS = 1'b0; lastS = 1'b0; prevDone = 1'b0; idS = 0;
    FifoCount_i = '0;
    clearStats();
    test_reset();
    test_frame8();
    test_stop();
    test_overflow();
    test_threshold();
    test_reset_mid();
    test_decim();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
